pci_target_ctrl: RTL and testbench



---
 rtl/pci_pkg.sv | 31 +++
 rtl/pci_tgt_read_slot.sv | 107 ++++++++++
 rtl/pci_target_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pci_target_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI target controller: command codes, response codes
// and the state encodings of the bus-side FSM and the delayed-read slot.
package pci_pkg;

   localparam logic [3:0] CMD_IO_READ   = 4'h2;
   localparam logic [3:0] CMD_IO_WRITE  = 4'h3;
   localparam logic [3:0] CMD_MEM_READ  = 4'h6;
   localparam logic [3:0] CMD_MEM_WRITE = 4'h7;
   localparam logic [3:0] CMD_CFG_READ  = 4'hA;
   localparam logic [3:0] CMD_CFG_WRITE = 4'hB;

   localparam logic [1:0] RESP_OK     = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      BUS_IDLE,
      BUS_WRITE,
      BUS_READ,
      BUS_RETRY,
      BUS_ABORT
   } bus_state_t;

   typedef enum logic [1:0] {
      SLOT_EMPTY,
      SLOT_ISSUE,
      SLOT_WAIT,
      SLOT_HOLD
   } slot_state_t;

endpackage

// File: rtl/pci_tgt_read_slot.sv
// One-entry delayed-read slot: holds the retried address, fetches it over the register
// bus and keeps the data until the matching retry. Optional timeout: PCI_TGT_DISCARD_EN.
module pci_tgt_read_slot
   import pci_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DISCARD_CYCLES = 32768
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic [ADDR_W-3:0] cap_addr,
   input  logic              consume,
   input  logic              read_active,
   output slot_state_t       state,
   output logic [ADDR_W-3:0] slot_addr,
   output logic [31:0]       slot_data,
   output logic              slot_err,
   output logic [ADDR_W-1:0] reg_raddr,
   output logic              reg_rvalid,
   input  logic              reg_rready,
   input  logic [31:0]       reg_rdata,
   input  logic              reg_rdvalid,
   input  logic              reg_rderr
);

   slot_state_t state_next;
   logic        load_data;
   logic        discard;

`ifdef PCI_TGT_DISCARD_EN
   localparam logic [15:0] DISCARD_LAST = 16'(DISCARD_CYCLES - 1);
   logic [15:0] hold_cnt;

   // Counter sits at zero outside HOLD so every entry to HOLD starts a fresh timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_cnt <= '0;
      else if (state != SLOT_HOLD)
         hold_cnt <= '0;
      else if (hold_cnt != DISCARD_LAST)
         hold_cnt <= hold_cnt + 16'd1;
   end

   assign discard = (state == SLOT_HOLD) && (hold_cnt == DISCARD_LAST) && !read_active;
`else
   logic unused_discard;
   assign unused_discard = read_active ^ (DISCARD_CYCLES > 0);
   assign discard        = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= SLOT_EMPTY;
      else
         state <= state_next;
   end

   // Read data may come back in the same cycle the request is accepted
   always_comb begin
      state_next = state;
      load_data  = 1'b0;
      case (state)
         SLOT_EMPTY:
            if (capture)
               state_next = SLOT_ISSUE;
         SLOT_ISSUE:
            if (reg_rready) begin
               if (reg_rdvalid) begin
                  load_data  = 1'b1;
                  state_next = SLOT_HOLD;
               end else begin
                  state_next = SLOT_WAIT;
               end
            end
         SLOT_WAIT:
            if (reg_rdvalid) begin
               load_data  = 1'b1;
               state_next = SLOT_HOLD;
            end
         SLOT_HOLD:
            if (consume || discard)
               state_next = SLOT_EMPTY;
         default:
            state_next = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_addr <= '0;
         slot_data <= '0;
         slot_err  <= 1'b0;
      end else begin
         if (state == SLOT_EMPTY && capture)
            slot_addr <= cap_addr;
         if (load_data) begin
            slot_data <= reg_rdata;
            slot_err  <= reg_rderr;
         end
      end
   end

   assign reg_rvalid = (state == SLOT_ISSUE);
   assign reg_raddr  = {slot_addr, 2'b00};

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI target-side controller: BAR hit decode, posted single-beat writes and delayed
// reads through pci_tgt_read_slot. Optional read-slot timeout: PCI_TGT_DISCARD_EN.
module pci_target_ctrl
   import pci_pkg::*;
#(
   parameter int BAR_INDEX      = 0,
   parameter int ADDR_W         = 16,
   parameter int DISCARD_CYCLES = 32768
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ADDR,
   input  logic              ADDR_VLD,
   input  logic [7:0]        BASE_HIT,
   input  logic              S_WRDN,
   input  logic [3:0]        S_CBE,
   input  logic              S_DATA,
   input  logic              S_DATA_VLD,
   input  logic              S_SRC_EN,
   input  logic [31:0]       ADIO_OUT,
   output logic [31:0]       ADIO_IN,
   output logic              S_READY,
   output logic              S_TERM,
   output logic              S_ABORT,
   output logic [ADDR_W-1:0] reg_waddr,
   output logic [31:0]       reg_wdata,
   output logic [3:0]        reg_wstrb,
   output logic              reg_wvalid,
   input  logic              reg_wready,
   output logic [ADDR_W-1:0] reg_raddr,
   output logic              reg_rvalid,
   input  logic              reg_rready,
   input  logic [31:0]       reg_rdata,
   input  logic              reg_rdvalid,
   input  logic              reg_rderr
);

   localparam int AW = ADDR_W - 2;

   bus_state_t  bus_state, bus_next;
   slot_state_t slot_state;
   logic [AW-1:0] txn_addr, wr_addr, slot_addr;
   logic [31:0]   slot_data;
   logic          slot_err;
   logic          hit, seen_data, bus_leave;
   logic          slot_capture, slot_consume, read_active, wr_taken;
   logic          unused_inputs;

   assign hit       = ADDR_VLD & BASE_HIT[BAR_INDEX];
   assign bus_leave = seen_data & ~S_DATA;
   assign unused_inputs = ^{S_SRC_EN, ADDR, BASE_HIT};

   // Writes are retried while a posted write is pending or a delayed read is in flight
   always_comb begin
      bus_next     = bus_state;
      slot_capture = 1'b0;
      case (bus_state)
         BUS_IDLE:
            if (hit) begin
               if (S_WRDN) begin
                  if (reg_wvalid || slot_state == SLOT_ISSUE || slot_state == SLOT_WAIT)
                     bus_next = BUS_RETRY;
                  else
                     bus_next = BUS_WRITE;
               end else begin
                  case (slot_state)
                     SLOT_EMPTY: begin
                        slot_capture = 1'b1;
                        bus_next     = BUS_RETRY;
                     end
                     SLOT_HOLD:
                        if (slot_addr == ADDR[ADDR_W-1:2])
                           bus_next = slot_err ? BUS_ABORT : BUS_READ;
                        else
                           bus_next = BUS_RETRY;
                     default:
                        bus_next = BUS_RETRY;
                  endcase
               end
            end
         default:
            if (bus_leave)
               bus_next = BUS_IDLE;
      endcase
   end

   assign slot_consume = (bus_state == BUS_READ && S_DATA_VLD) ||
                         (bus_state == BUS_ABORT && bus_leave);
   assign read_active  = (bus_state == BUS_READ) || (bus_state == BUS_ABORT) ||
                         (bus_next == BUS_READ) || (bus_next == BUS_ABORT);

   // Handshake outputs are registered from the next state so they appear the cycle after ADDR_VLD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_state <= BUS_IDLE;
         seen_data <= 1'b0;
         S_READY   <= 1'b0;
         S_TERM    <= 1'b0;
         S_ABORT   <= 1'b0;
         ADIO_IN   <= '0;
         txn_addr  <= '0;
      end else begin
         bus_state <= bus_next;
         seen_data <= (bus_state != BUS_IDLE) && (bus_next != BUS_IDLE) && (seen_data || S_DATA);
         S_READY   <= (bus_next == BUS_WRITE) || (bus_next == BUS_READ);
         S_TERM    <= (bus_next == BUS_WRITE) || (bus_next == BUS_READ) || (bus_next == BUS_RETRY);
         S_ABORT   <= (bus_next == BUS_ABORT);
         ADIO_IN   <= (bus_next == BUS_READ) ? slot_data : '0;
         if (bus_state == BUS_IDLE && hit)
            txn_addr <= ADDR[ADDR_W-1:2];
      end
   end

   // One data beat per write transaction; all-zero byte enables complete without a register write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_wvalid <= 1'b0;
         reg_wdata  <= '0;
         reg_wstrb  <= '0;
         wr_addr    <= '0;
         wr_taken   <= 1'b0;
      end else begin
         if (bus_state == BUS_WRITE && S_DATA_VLD && !wr_taken) begin
            wr_taken   <= 1'b1;
            wr_addr    <= txn_addr;
            reg_wdata  <= ADIO_OUT;
            reg_wstrb  <= ~S_CBE;
            reg_wvalid <= (S_CBE != 4'hF);
         end else if (reg_wvalid && reg_wready) begin
            reg_wvalid <= 1'b0;
         end
         if (bus_next == BUS_IDLE)
            wr_taken <= 1'b0;
      end
   end

   assign reg_waddr = {wr_addr, 2'b00};

   pci_tgt_read_slot #(
      .ADDR_W         (ADDR_W),
      .DISCARD_CYCLES (DISCARD_CYCLES)
   ) u_read_slot (
      .clk         (clk),
      .rst         (rst),
      .capture     (slot_capture),
      .cap_addr    (ADDR[ADDR_W-1:2]),
      .consume     (slot_consume),
      .read_active (read_active),
      .state       (slot_state),
      .slot_addr   (slot_addr),
      .slot_data   (slot_data),
      .slot_err    (slot_err),
      .reg_raddr   (reg_raddr),
      .reg_rvalid  (reg_rvalid),
      .reg_rready  (reg_rready),
      .reg_rdata   (reg_rdata),
      .reg_rdvalid (reg_rdvalid),
      .reg_rderr   (reg_rderr)
   );

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Directed bench for pci_target_ctrl: posted writes, delayed reads, retry/abort and
// the PCI_TGT_DISCARD_EN timeout (checked in whichever mode the build selects).
module tb_pci_target_ctrl;

   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       ADDR;
   logic              ADDR_VLD;
   logic [7:0]        BASE_HIT;
   logic              S_WRDN;
   logic [3:0]        S_CBE;
   logic              S_DATA;
   logic              S_DATA_VLD;
   logic              S_SRC_EN;
   logic [31:0]       ADIO_OUT;
   logic [31:0]       ADIO_IN;
   logic              S_READY, S_TERM, S_ABORT;
   logic [ADDR_W-1:0] reg_waddr, reg_raddr;
   logic [31:0]       reg_wdata, reg_rdata;
   logic [3:0]        reg_wstrb;
   logic              reg_wvalid, reg_wready, reg_rvalid, reg_rready, reg_rdvalid, reg_rderr;

   int checks = 0;
   int errors = 0;

   logic        rdy, trm, abt;
   logic [31:0] adio;

   always #5 clk = ~clk;

   pci_target_ctrl #(
      .BAR_INDEX      (0),
      .ADDR_W         (ADDR_W),
      .DISCARD_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ADDR        (ADDR),
      .ADDR_VLD    (ADDR_VLD),
      .BASE_HIT    (BASE_HIT),
      .S_WRDN      (S_WRDN),
      .S_CBE       (S_CBE),
      .S_DATA      (S_DATA),
      .S_DATA_VLD  (S_DATA_VLD),
      .S_SRC_EN    (S_SRC_EN),
      .ADIO_OUT    (ADIO_OUT),
      .ADIO_IN     (ADIO_IN),
      .S_READY     (S_READY),
      .S_TERM      (S_TERM),
      .S_ABORT     (S_ABORT),
      .reg_waddr   (reg_waddr),
      .reg_wdata   (reg_wdata),
      .reg_wstrb   (reg_wstrb),
      .reg_wvalid  (reg_wvalid),
      .reg_wready  (reg_wready),
      .reg_raddr   (reg_raddr),
      .reg_rvalid  (reg_rvalid),
      .reg_rready  (reg_rready),
      .reg_rdata   (reg_rdata),
      .reg_rdvalid (reg_rdvalid),
      .reg_rderr   (reg_rderr)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Address phase, one data-phase cycle (where the response is sampled), then S_DATA drops
   task automatic applyStimulus(input logic [31:0] addr, input logic is_hit, input logic wrdn,
                                input logic [3:0] cbe, input logic [31:0] wdata, input logic vld);
      ADDR     = addr;
      ADDR_VLD = 1'b1;
      BASE_HIT = is_hit ? 8'h01 : 8'h02;
      S_WRDN   = wrdn;
      tick();
      ADDR_VLD   = 1'b0;
      BASE_HIT   = 8'h00;
      S_DATA     = 1'b1;
      S_DATA_VLD = vld;
      S_CBE      = cbe;
      ADIO_OUT   = wdata;
      rdy  = S_READY;
      trm  = S_TERM;
      abt  = S_ABORT;
      adio = ADIO_IN;
      tick();
      S_DATA     = 1'b0;
      S_DATA_VLD = 1'b0;
      tick();
   endtask

   task automatic checkResp(input string tag, input logic er, input logic et, input logic ea);
      checkOutput({tag, "_ready"}, 32'(rdy), 32'(er));
      checkOutput({tag, "_term"},  32'(trm), 32'(et));
      checkOutput({tag, "_abort"}, 32'(abt), 32'(ea));
   endtask

   task automatic readReturn(input logic [31:0] data, input logic err);
      reg_rready  = 1'b1;
      reg_rdvalid = 1'b1;
      reg_rdata   = data;
      reg_rderr   = err;
      tick();
      reg_rready  = 1'b0;
      reg_rdvalid = 1'b0;
      reg_rdata   = '0;
      reg_rderr   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ADDR = '0; ADDR_VLD = 0; BASE_HIT = '0; S_WRDN = 0; S_CBE = '0;
      S_DATA = 0; S_DATA_VLD = 0; S_SRC_EN = 0; ADIO_OUT = '0;
      reg_wready = 0; reg_rready = 0; reg_rdata = '0; reg_rdvalid = 0; reg_rderr = 0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      checkOutput("rst_ready",  32'(S_READY),    32'd0);
      checkOutput("rst_term",   32'(S_TERM),     32'd0);
      checkOutput("rst_abort",  32'(S_ABORT),    32'd0);
      checkOutput("rst_adio",   ADIO_IN,         32'd0);
      checkOutput("rst_wvalid", 32'(reg_wvalid), 32'd0);
      checkOutput("rst_rvalid", 32'(reg_rvalid), 32'd0);

      // Posted write, held while reg_wready stays low
      applyStimulus(32'h0000_0010, 1'b1, 1'b1, 4'b0000, 32'hDEAD_BEEF, 1'b1);
      checkResp("wr1", 1'b1, 1'b1, 1'b0);
      checkOutput("wr1_release", 32'(S_TERM), 32'd0);
      checkOutput("wr1_wvalid", 32'(reg_wvalid), 32'd1);
      checkOutput("wr1_waddr",  32'(reg_waddr),  32'h10);
      checkOutput("wr1_wdata",  reg_wdata,       32'hDEAD_BEEF);
      checkOutput("wr1_wstrb",  32'(reg_wstrb),  32'hF);
      tick();
      checkOutput("wr1_hold", 32'(reg_wvalid), 32'd1);

      applyStimulus(32'h0000_0014, 1'b1, 1'b1, 4'b0000, 32'h0BAD_0BAD, 1'b0);
      checkResp("wr2_busy", 1'b0, 1'b1, 1'b0);
      checkOutput("wr2_waddr", 32'(reg_waddr), 32'h10);
      checkOutput("wr2_wdata", reg_wdata,      32'hDEAD_BEEF);
      reg_wready = 1'b1;
      tick();
      reg_wready = 1'b0;
      checkOutput("wr1_accept", 32'(reg_wvalid), 32'd0);

      applyStimulus(32'h0000_0010, 1'b0, 1'b1, 4'b0000, 32'h1111_1111, 1'b1);
      checkResp("nohit", 1'b0, 1'b0, 1'b0);
      checkOutput("nohit_wvalid", 32'(reg_wvalid), 32'd0);

      // Delayed read: first attempt retried and fetched over the register bus
      applyStimulus(32'h0000_0020, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
      checkResp("rd1_retry", 1'b0, 1'b1, 1'b0);
      checkOutput("rd1_rvalid", 32'(reg_rvalid), 32'd1);
      checkOutput("rd1_raddr",  32'(reg_raddr),  32'h20);

      applyStimulus(32'h0000_0030, 1'b1, 1'b1, 4'b0000, 32'h2222_2222, 1'b1);
      checkResp("wr_order", 1'b0, 1'b1, 1'b0);
      checkOutput("wr_order_wvalid", 32'(reg_wvalid), 32'd0);

      reg_rready = 1'b1;
      tick();
      reg_rready = 1'b0;
      checkOutput("rd1_accepted", 32'(reg_rvalid), 32'd0);
      repeat (4) tick();
      readReturn(32'h1234_5678, 1'b0);

      applyStimulus(32'h0000_0024, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
      checkResp("rd_other", 1'b0, 1'b1, 1'b0);
      checkOutput("rd_other_rvalid", 32'(reg_rvalid), 32'd0);

      applyStimulus(32'h0000_0020, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1);
      checkResp("rd1_done", 1'b1, 1'b1, 1'b0);
      checkOutput("rd1_data", adio, 32'h1234_5678);

      // Slot emptied by the completed read, so the same address starts a fresh fetch
      applyStimulus(32'h0000_0020, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
      checkResp("rd2_retry", 1'b0, 1'b1, 1'b0);
      checkOutput("rd2_rvalid", 32'(reg_rvalid), 32'd1);
      readReturn(32'hBAD0_BAD0, 1'b1);
      checkOutput("rd2_accepted", 32'(reg_rvalid), 32'd0);

      applyStimulus(32'h0000_0020, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
      checkResp("rd2_abort", 1'b0, 1'b0, 1'b1);
      checkOutput("rd2_abort_adio", adio, 32'd0);

      applyStimulus(32'h0000_0020, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
      checkResp("rd3_retry", 1'b0, 1'b1, 1'b0);
      checkOutput("rd3_rvalid", 32'(reg_rvalid), 32'd1);
      readReturn(32'hCAFE_F00D, 1'b0);

      // Writes while data is held: all-zero strobes, then a partial-strobe write
      applyStimulus(32'h0000_0040, 1'b1, 1'b1, 4'b1111, 32'h3333_3333, 1'b1);
      checkResp("wr_nostrb", 1'b1, 1'b1, 1'b0);
      checkOutput("wr_nostrb_wvalid", 32'(reg_wvalid), 32'd0);

      applyStimulus(32'h0000_0044, 1'b1, 1'b1, 4'b1010, 32'h1122_3344, 1'b1);
      checkResp("wr_part", 1'b1, 1'b1, 1'b0);
      checkOutput("wr_part_wvalid", 32'(reg_wvalid), 32'd1);
      checkOutput("wr_part_waddr",  32'(reg_waddr),  32'h44);
      checkOutput("wr_part_wstrb",  32'(reg_wstrb),  32'h5);
      checkOutput("wr_part_wdata",  reg_wdata,       32'h1122_3344);
      reg_wready = 1'b1;
      tick();
      reg_wready = 1'b0;
      checkOutput("wr_part_accept", 32'(reg_wvalid), 32'd0);

      applyStimulus(32'h0000_0020, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1);
      checkResp("rd3_done", 1'b1, 1'b1, 1'b0);
      checkOutput("rd3_data", adio, 32'hCAFE_F00D);

      // Held data left untouched well past the 16-cycle timeout
      applyStimulus(32'h0000_0028, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
      checkResp("rd4_retry", 1'b0, 1'b1, 1'b0);
      checkOutput("rd4_raddr", 32'(reg_raddr), 32'h28);
      readReturn(32'h55AA_55AA, 1'b0);
      repeat (20) tick();
      applyStimulus(32'h0000_0028, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1);
`ifdef PCI_TGT_DISCARD_EN
      checkResp("rd4_discarded", 1'b0, 1'b1, 1'b0);
      checkOutput("rd4_refetch", 32'(reg_rvalid), 32'd1);
      checkOutput("rd4_refetch_addr", 32'(reg_raddr), 32'h28);
`else
      checkResp("rd4_kept", 1'b1, 1'b1, 1'b0);
      checkOutput("rd4_data", adio, 32'h55AA_55AA);
      checkOutput("rd4_no_refetch", 32'(reg_rvalid), 32'd0);
`endif

      // Reset drops a pending posted write
      applyStimulus(32'h0000_0050, 1'b1, 1'b1, 4'b0000, 32'h4444_4444, 1'b1);
`ifdef PCI_TGT_DISCARD_EN
      checkResp("wr_prerst", 1'b0, 1'b1, 1'b0);
`else
      checkResp("wr_prerst", 1'b1, 1'b1, 1'b0);
      checkOutput("wr_prerst_wvalid", 32'(reg_wvalid), 32'd1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      checkOutput("rst2_wvalid", 32'(reg_wvalid), 32'd0);
      checkOutput("rst2_rvalid", 32'(reg_rvalid), 32'd0);
      checkOutput("rst2_term",   32'(S_TERM),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
